// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian array, one outstanding load/store.
// Response appears LATENCY cycles after acceptance and is held until rsp_ready.
module dmem_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int IDX_W = $clog2(DEPTH_BYTES);
   localparam int CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [7:0]       mem_q [DEPTH_BYTES];

   logic             accept;
   logic [3:0]       nbytes;
   logic [2:0]       align_mask;
   logic             misaligned;
   logic             out_of_range;
   logic             req_err;
   logic [IDX_W-1:0] idx;
   logic [63:0]      raw;
   logic [63:0]      ext;
   logic             sext;

   assign accept    = (state_q == IDLE) && req_valid;
   assign idx       = req_addr[IDX_W-1:0];
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // Range check uses a 65-bit sum so addresses near 2^64 cannot wrap into range.
   always_comb begin
      nbytes       = 4'd1 << req_size;
      align_mask   = 3'(nbytes - 4'd1);
      misaligned   = (req_addr[2:0] & align_mask) != 3'd0;
      out_of_range = ({1'b0, req_addr} + 65'(nbytes)) > 65'(DEPTH_BYTES);
      req_err      = misaligned | out_of_range;
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < 8; i++) begin
         raw[8*i +: 8] = mem_q[idx + IDX_W'(i)];
      end
      sext = ~req_unsigned;
      case (req_size)
         2'd0:    ext = {{56{sext & raw[7]}},  raw[7:0]};
         2'd1:    ext = {{48{sext & raw[15]}}, raw[15:0]};
         2'd2:    ext = {{32{sext & raw[31]}}, raw[31:0]};
         default: ext = raw;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rdata_d = (req_we || req_err) ? 64'd0 : ext;
               err_d   = req_err;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  cnt_d   = CNT_W'(LATENCY - 1);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; only the accepting edge of a legal store writes.
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) mem_q[idx + IDX_W'(i)] <= req_wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_dmem_responder;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata, rsp_rdata;

   logic        req_valid1, req_ready1, req_we1, req_unsigned1, rsp_valid1, rsp_ready1, rsp_err1;
   logic [1:0]  req_size1;
   logic [63:0] req_addr1, req_wdata1, rsp_rdata1;

   dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
      .req_size(req_size1), .req_unsigned(req_unsigned1), .req_addr(req_addr1), .req_wdata(req_wdata1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rd;
      logic        er;
   } vec_t;

   exp_t sb[$];
   vec_t vq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [63:0] rd, input logic er);
      vec_t v;
      v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd; v.er = er;
      vq.push_back(v);
   endtask

   // Drives one request on u0, records the expectation, and returns what came back.
   task automatic do_req(input vec_t v, output logic [63:0] rd, output logic er, output int lat);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      e.rdata = v.rd; e.err = v.er; e.lat = 2;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_u0 ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      total++;
      if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_rdata1 !== 64'd0 || rsp_err1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_u1 ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready1, rsp_valid1, rsp_rdata1, rsp_err1);
      end
   endtask

   task automatic test_byte_half_word();
      logic [63:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      vq.delete();
      add(1, 2'd0, 0, 64'd0,  64'h7777_7777_7777_77AA, 64'd0, 0);
      add(0, 2'd0, 0, 64'd0,  64'd0, 64'hFFFF_FFFF_FFFF_FFAA, 0);
      add(0, 2'd0, 1, 64'd0,  64'd0, 64'h0000_0000_0000_00AA, 0);
      add(0, 2'd0, 0, 64'd1,  64'd0, 64'd0, 0);
      add(1, 2'd1, 0, 64'd4,  64'h5555_5555_5555_BEEF, 64'd0, 0);
      add(0, 2'd1, 0, 64'd4,  64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 0);
      add(0, 2'd2, 1, 64'd4,  64'd0, 64'h0000_0000_0000_BEEF, 0);
      add(1, 2'd2, 0, 64'd8,  64'h1111_2222_DEAD_BEEF, 64'd0, 0);
      add(0, 2'd2, 0, 64'd8,  64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 0);
      add(0, 2'd2, 1, 64'd8,  64'd0, 64'h0000_0000_DEAD_BEEF, 0);
      add(0, 2'd3, 0, 64'd8,  64'd0, 64'h0000_0000_DEAD_BEEF, 0);
      foreach (vq[k]) begin
         do_req(vq[k], rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err) begin
            bad++;
            $display("FAIL bhw[%0d] rdata=%h err=%b want rdata=%h err=%b", k, rd, er, e.rdata, e.err);
         end
         total++;
         if (lat !== e.lat) begin
            bad++;
            $display("FAIL bhw_lat[%0d] got %0d want %0d", k, lat, e.lat);
         end
      end
   endtask

   task automatic test_double();
      logic [63:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      vq.delete();
      add(1, 2'd3, 0, 64'd16, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
      add(0, 2'd0, 0, 64'd17, 64'd0, 64'hFFFF_FFFF_FFFF_FFCD, 0);
      add(0, 2'd3, 0, 64'd16, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
      add(0, 2'd3, 1, 64'd16, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
      add(0, 2'd0, 0, 64'd20, 64'd0, 64'h0000_0000_0000_0067, 0);
      add(0, 2'd1, 1, 64'd18, 64'd0, 64'h0000_0000_0000_89AB, 0);
      add(0, 2'd1, 0, 64'd18, 64'd0, 64'hFFFF_FFFF_FFFF_89AB, 0);
      add(0, 2'd2, 0, 64'd20, 64'd0, 64'h0000_0000_0123_4567, 0);
      foreach (vq[k]) begin
         do_req(vq[k], rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL dbl[%0d] rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                     k, rd, er, lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_errors();
      logic [63:0] rd;
      logic        er;
      int          lat;
      exp_t        e;
      vq.delete();
      add(0, 2'd1, 0, 64'd5, 64'd0, 64'd0, 1);
      add(1, 2'd2, 0, 64'(DEPTH - 2), 64'hCAFE_BABE, 64'd0, 1);
      add(0, 2'd0, 1, 64'(DEPTH - 2), 64'd0, 64'd0, 0);
      add(0, 2'd0, 1, 64'(DEPTH - 1), 64'd0, 64'd0, 0);
      add(1, 2'd0, 0, 64'(DEPTH - 1), 64'h5A, 64'd0, 0);
      add(0, 2'd0, 1, 64'(DEPTH - 1), 64'd0, 64'h5A, 0);
      add(0, 2'd1, 1, 64'(DEPTH - 2), 64'd0, 64'h5A00, 0);
      add(0, 2'd3, 0, 64'(DEPTH - 8), 64'd0, 64'h5A00_0000_0000_0000, 0);
      add(0, 2'd3, 0, 64'(DEPTH), 64'd0, 64'd0, 1);
      add(0, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1);
      add(0, 2'd2, 0, 64'h0000_0001_0000_0000, 64'd0, 64'd0, 1);
      add(1, 2'd3, 0, 64'(DEPTH), 64'h1234_5678_9ABC_DEF0, 64'd0, 1);
      add(0, 2'd0, 1, 64'd0, 64'd0, 64'h0000_0000_0000_00AA, 0);
      foreach (vq[k]) begin
         do_req(vq[k], rd, er, lat);
         e = sb.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
            bad++;
            $display("FAIL err[%0d] rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                     k, rd, er, lat, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t        e;
      vec_t        v;
      logic [63:0] rd;
      logic        er;
      int          lat;
      int          guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'd16;
      e.rdata = 64'h0123_4567_89AB_CDEF; e.err = 1'b0; e.lat = 2;
      sb.push_back(e);
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_busy ready=%b valid=%b want 0 0", req_ready, rsp_valid);
      end
      // A store offered while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'd16; req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
      guard = 0;
      while (!rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b0;
      e = sb.pop_front();
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         bad++;
         $display("FAIL bp_first valid=%b rdata=%h err=%b want 1 %h %b", rsp_valid, rsp_rdata, rsp_err,
                  e.rdata, e.err);
      end
      repeat (3) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      v.we = 0; v.sz = 2'd3; v.uns = 0; v.addr = 64'd16; v.wdata = 64'd0;
      v.rd = 64'h0123_4567_89AB_CDEF; v.er = 0;
      do_req(v, rd, er, lat);
      e = sb.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err) begin
         bad++;
         $display("FAIL bp_ignored_store rdata=%h err=%b want %h %b", rd, er, e.rdata, e.err);
      end
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      vec_t        v;
      logic [63:0] rd;
      logic        er;
      int          lat;
      int          guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 64'd24; req_wdata = 64'hFFFF;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge clk);
      rst = 1'b0;
      // Reset while a load response with non-zero data is pending.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'd16;
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      rst = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge clk);
      rst = 1'b0;
      v.we = 0; v.sz = 2'd3; v.uns = 0; v.addr = 64'd24; v.wdata = 64'd0; v.rd = 64'hFFFF; v.er = 0;
      do_req(v, rd, er, lat);
      e = sb.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
         bad++;
         $display("FAIL rst_store_kept rdata=%h err=%b lat=%0d want %h %b %0d", rd, er, lat, e.rdata, e.err, e.lat);
      end
   endtask

   task automatic test_latency1();
      exp_t e;
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = 1'b1; req_size1 = 2'd3; req_unsigned1 = 1'b0;
      req_addr1 = 64'd24; req_wdata1 = 64'hFFFF;
      e.rdata = 64'd0; e.err = 1'b0; e.lat = 1;
      sb.push_back(e);
      @(negedge clk);
      req_valid1 = 1'b0;
      e = sb.pop_front();
      total++;
      if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== e.rdata || rsp_err1 !== e.err || req_ready1 !== 1'b0) begin
         bad++;
         $display("FAIL l1_store valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                  rsp_valid1, rsp_rdata1, rsp_err1, req_ready1, e.rdata, e.err);
      end
      rsp_ready1 = 1'b1;
      @(negedge clk);
      rsp_ready1 = 1'b0;
      req_valid1 = 1'b1; req_we1 = 1'b0; req_size1 = 2'd3; req_addr1 = 64'd24;
      e.rdata = 64'hFFFF; e.err = 1'b0; e.lat = 1;
      sb.push_back(e);
      @(negedge clk);
      req_valid1 = 1'b0;
      e = sb.pop_front();
      total++;
      if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== e.rdata || rsp_err1 !== e.err) begin
         bad++;
         $display("FAIL l1_load valid=%b rdata=%h err=%b want 1 %h %b", rsp_valid1, rsp_rdata1, rsp_err1,
                  e.rdata, e.err);
      end
      rst = 1'b1;
      #1;
      total++;
      if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_rdata1 !== 64'd0 || rsp_err1 !== 1'b0) begin
         bad++;
         $display("FAIL l1_rst ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                  req_ready1, rsp_valid1, rsp_rdata1, rsp_err1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = 1'b0; req_size1 = 2'd1; req_unsigned1 = 1'b0; req_addr1 = 64'd24;
      e.rdata = 64'hFFFF_FFFF_FFFF_FFFF; e.err = 1'b0; e.lat = 1;
      sb.push_back(e);
      @(negedge clk);
      req_valid1 = 1'b0;
      e = sb.pop_front();
      total++;
      if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== e.rdata || rsp_err1 !== e.err) begin
         bad++;
         $display("FAIL l1_after_rst valid=%b rdata=%h err=%b want 1 %h %b", rsp_valid1, rsp_rdata1,
                  rsp_err1, e.rdata, e.err);
      end
      rsp_ready1 = 1'b1;
      @(negedge clk);
      rsp_ready1 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
      req_valid1 = 1'b0; req_we1 = 1'b0; req_size1 = 2'd0; req_unsigned1 = 1'b0;
      req_addr1 = 64'd0; req_wdata1 = 64'd0; rsp_ready1 = 1'b0;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_byte_half_word();
      test_double();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_latency1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
